imm_extend_pipe: RTL

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe_pkg.sv | 29 ++
 rtl/imm_extend_pipe_core.sv | 35 +++
 rtl/imm_extend_pipe.sv | 99 +++++++++
 3 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// Shared processor constants: ALU ops, immediate modes, skid states.
// Imported by the immediate-extension pipe and its mux core.
package imm_extend_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    MODE_SEXT   = 2'd0,
    MODE_ZEXT   = 2'd1,
    MODE_UPPER  = 2'd2,
    MODE_BRANCH = 2'd3
  } imm_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_st_e;

endpackage

// File: rtl/imm_extend_pipe_core.sv
// Combinational immediate extension mux.
// Ports: imm (IN_W raw field), mode (imm_mode_e), ext (OUT_W result).
module imm_extend_core
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  imm_mode_e        mode,
  output logic [OUT_W-1:0] ext
);

  localparam int PAD = OUT_W - IN_W;

  // Branch mode drops two sign copies; OUT_W must leave room for them.
  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_extend_core: OUT_W must be >= IN_W+2");
  end

  logic [OUT_W-1:0] sext;

  assign sext = {{PAD{imm[IN_W-1]}}, imm};

  always_comb begin
    ext = '0;
    unique case (mode)
      MODE_SEXT:   ext = sext;
      MODE_ZEXT:   ext = {{PAD{1'b0}}, imm};
      MODE_UPPER:  ext = {imm, {PAD{1'b0}}};
      MODE_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extension stage with a 2-entry skid buffer.
// In: Clk,Rst_n,Flush,InValid/InImm/InMode/InTag,OutReady. Out: InReady,OutValid,OutExt,OutTag.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [IN_W-1:0]  InImm,
  input  logic [1:0]       InMode,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [OUT_W-1:0] OutExt,
  output logic [TAG_W-1:0] OutTag
);

  skid_st_e         state;
  logic [OUT_W-1:0] ext_d;
  logic [OUT_W-1:0] skid_ext;
  logic [TAG_W-1:0] skid_tag;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = InValid & InReady;
  assign out_xfer = OutValid & OutReady;

  imm_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (InImm),
    .mode (imm_mode_e'(InMode)),
    .ext  (ext_d)
  );

  // InReady and OutValid are registered copies of the state decode,
  // so OutReady never reaches InReady combinationally.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ST_EMPTY;
      InReady  <= 1'b1;
      OutValid <= 1'b0;
      OutExt   <= '0;
      OutTag   <= '0;
      skid_ext <= '0;
      skid_tag <= '0;
    end else if (Flush) begin
      state    <= ST_EMPTY;
      InReady  <= 1'b1;
      OutValid <= 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            OutExt   <= ext_d;
            OutTag   <= InTag;
            OutValid <= 1'b1;
            state    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            OutExt <= ext_d;
            OutTag <= InTag;
          end else if (in_xfer) begin
            skid_ext <= ext_d;
            skid_tag <= InTag;
            InReady  <= 1'b0;
            state    <= ST_TWO;
          end else if (out_xfer) begin
            OutValid <= 1'b0;
            state    <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            OutExt  <= skid_ext;
            OutTag  <= skid_tag;
            InReady <= 1'b1;
            state   <= ST_ONE;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          InReady  <= 1'b1;
          OutValid <= 1'b0;
        end
      endcase
    end
  end

endmodule
